// File: rtl/mem_stage.sv
// RISC-V MEM stage: drives a ready/valid data-memory port for lw/sw/lb/lbu/sb,
// stalls upstream while an access is outstanding and registers the MEM/WB payload.
module mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] aluresult,
  input  logic [XLEN-1:0] writedata,
  input  logic            memread,
  input  logic            memwrite,
  input  logic            memtoreg,
  input  logic            regwrite,
  input  logic            bitype,
  input  logic            unsign,
  input  logic            branch,
  input  logic            zero,
  input  logic [4:0]      rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            pcsrc,
  output logic            err,
  output logic            wb_valid,
  output logic            wb_regwrite,
  output logic            wb_memtoreg,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_aluresult,
  output logic [XLEN-1:0] wb_memdata
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  function automatic logic [31:0] fmt_wdata(input logic byte_op, input logic [31:0] data);
    if (byte_op) return {4{data[7:0]}};
    else         return data;
  endfunction

  function automatic logic [3:0] fmt_wstrb(input logic byte_op, input logic [1:0] off);
    if (byte_op) return 4'b0001 << off;
    else         return 4'b1111;
  endfunction

  function automatic logic [31:0] fmt_load(input logic byte_op, input logic zext,
                                           input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0] b;
    b = rdata[{off, 3'b000} +: 8];
    if (!byte_op)  return rdata;
    else if (zext) return {24'h000000, b};
    else           return {{24{b[7]}}, b};
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_count;
  logic        r_req, r_we, r_err;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wb_valid, r_wb_regwrite, r_wb_memtoreg;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_aluresult, r_wb_memdata;

  logic        w_memop, w_misaligned, w_start, w_timeout, w_access;
  logic [31:0] w_load_data;

  assign w_memop      = in_valid & (memread | memwrite);
  assign w_misaligned = w_memop & ~bitype & (aluresult[1:0] != 2'b00);
  assign w_access     = (r_state == S_ACCESS);
  assign w_start      = (r_state == S_IDLE) & w_memop & ~w_misaligned;
  // ready in the last allowed cycle still wins over the abort
  assign w_timeout    = w_access & ~dmem_ready & (r_count == CNT_LAST);
  assign w_load_data  = fmt_load(bitype, unsign, aluresult[1:0], dmem_rdata);

  assign pcsrc        = in_valid & branch & zero;
  assign err          = r_err;
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign dmem_wstrb   = r_wstrb;
  assign wb_valid     = r_wb_valid;
  assign wb_regwrite  = r_wb_regwrite;
  assign wb_memtoreg  = r_wb_memtoreg;
  assign wb_rd        = r_wb_rd;
  assign wb_aluresult = r_wb_aluresult;
  assign wb_memdata   = r_wb_memdata;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next_state = S_ACCESS;
        else         w_next_state = S_IDLE;
      end
      S_ACCESS: begin
        if (dmem_ready || w_timeout) w_next_state = S_IDLE;
        else                         w_next_state = S_ACCESS;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // stall releases in the completing cycle so upstream advances on that edge
  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:   stall = w_start;
      S_ACCESS: stall = ~dmem_ready & ~w_timeout;
      default:  stall = 1'b0;
    endcase
  end

  // wait-cycle counter, cleared whenever not waiting in ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_count <= 8'd0;
    else if (w_access && !dmem_ready) r_count <= r_count + 8'd1;
    else                              r_count <= 8'd0;
  end

  // memory request registers, held stable for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_wstrb <= 4'b0000;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= memwrite;
      r_addr  <= {aluresult[31:2], 2'b00};
      r_wdata <= fmt_wdata(bitype, writedata);
      r_wstrb <= fmt_wstrb(bitype, aluresult[1:0]);
    end else if (w_access && (dmem_ready || w_timeout)) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_wstrb <= 4'b0000;
    end else begin
      r_req   <= r_req;
    end
  end

  // sticky fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_err <= 1'b0;
    else if (((r_state == S_IDLE) && w_misaligned) || w_timeout) r_err <= 1'b1;
    else                                                 r_err <= r_err;
  end

  // MEM/WB pipeline register; stalled cycles insert a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_aluresult <= 32'h0000_0000;
      r_wb_memdata   <= 32'h0000_0000;
    end else if ((r_state == S_IDLE) && !w_start) begin
      r_wb_valid     <= in_valid;
      r_wb_regwrite  <= regwrite & in_valid & ~w_misaligned;
      r_wb_memtoreg  <= memtoreg & in_valid & ~w_misaligned;
      r_wb_rd        <= rd;
      r_wb_aluresult <= aluresult;
      r_wb_memdata   <= 32'h0000_0000;
    end else if (w_access && dmem_ready) begin
      r_wb_valid     <= 1'b1;
      r_wb_regwrite  <= regwrite & ~memwrite;
      r_wb_memtoreg  <= memtoreg & ~memwrite;
      r_wb_rd        <= rd;
      r_wb_aluresult <= aluresult;
      r_wb_memdata   <= memwrite ? 32'h0000_0000 : w_load_data;
    end else if (w_timeout) begin
      r_wb_valid     <= 1'b1;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_rd        <= rd;
      r_wb_aluresult <= aluresult;
      r_wb_memdata   <= 32'h0000_0000;
    end else begin
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases from the feature list plus
// randomized instructions checked against a transaction-level reference model.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, memread, memwrite, memtoreg, regwrite, bitype, unsign, branch, zero;
  logic [31:0] aluresult, writedata, dmem_rdata;
  logic [4:0]  rd;
  logic        dmem_ready;
  logic        dmem_req, dmem_we, stall, pcsrc, err;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_aluresult, wb_memdata;

  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;

  mem_stage #(.TIMEOUT(TO), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .aluresult(aluresult),
    .writedata(writedata), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .regwrite(regwrite), .bitype(bitype), .unsign(unsign), .branch(branch), .zero(zero),
    .rd(rd), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall), .pcsrc(pcsrc), .err(err),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_rd(wb_rd), .wb_aluresult(wb_aluresult), .wb_memdata(wb_memdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input logic bt, input logic us, input int off,
                                           input logic [31:0] rdata);
    logic [31:0] b;
    if (!bt) return rdata;
    b = (rdata >> (8 * off)) & 32'h0000_00FF;
    if (!us && b >= 32'h0000_0080) b = b + 32'hFFFF_FF00;
    return b;
  endfunction

  task automatic clear_inputs();
    in_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; regwrite = 1'b0;
    bitype = 1'b0; unsign = 1'b0; branch = 1'b0; zero = 1'b0; rd = 5'd0;
    aluresult = 32'h0; writedata = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
  endtask

  // Runs one instruction to its MEM/WB commit; memory answers after lat wait cycles.
  task automatic exec(input logic v, input logic mr, input logic mw, input logic mtr,
                      input logic rw, input logic bt, input logic us, input logic br,
                      input logic z, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdat, input logic [4:0] rdi, input int lat,
                      input string tag);
    logic        memop, mis, acc, tmo, store, exp_rw, done, saw_req;
    int          off, exp_stall, stall_cnt, n_acc;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    logic [3:0]  exp_wstrb;
    off       = int'(addr % 32'd4);
    memop     = v & (mr | mw);
    store     = mw;
    mis       = memop & !bt & (off != 0);
    acc       = memop & !mis;
    tmo       = acc & (lat >= TO);
    exp_stall = !acc ? 0 : (tmo ? TO : lat + 1);
    exp_rw    = !v ? 1'b0 : (!memop ? rw : ((mis || tmo || store) ? 1'b0 : rw));
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_wdata = bt ? (wd & 32'h0000_00FF) * 32'h0101_0101 : wd;
    exp_wstrb = bt ? 4'(1 << off) : 4'hF;
    exp_data  = (acc && !store && !tmo) ? ref_load(bt, us, off, rdat) : 32'h0;
    if (mis || tmo) exp_err = 1'b1;

    @(negedge clk);
    in_valid = v; memread = mr; memwrite = mw; memtoreg = mtr; regwrite = rw; bitype = bt;
    unsign = us; branch = br; zero = z; aluresult = addr; writedata = wd; rd = rdi;
    dmem_rdata = rdat; dmem_ready = 1'b0;
    done = 1'b0; saw_req = 1'b0; stall_cnt = 0; n_acc = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (dmem_req) begin
        n_acc++;
        dmem_ready = (n_acc > lat);
        checks++;
        if (dmem_we !== store || dmem_addr !== exp_addr ||
            (store && (dmem_wdata !== exp_wdata || dmem_wstrb !== exp_wstrb))) begin
          errors++;
          $display("FAIL %s dmem_port we=%b addr=%h wdata=%h wstrb=%b want we=%b addr=%h wdata=%h wstrb=%b",
                   tag, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, store, exp_addr, exp_wdata, exp_wstrb);
        end
        saw_req = 1'b1;
      end else begin
        dmem_ready = 1'b0;
      end
      #1;
      if (cyc == 0) begin
        checks++;
        if (pcsrc !== (v & br & z)) begin
          errors++;
          $display("FAIL %s pcsrc got %b want %b", tag, pcsrc, v & br & z);
        end
      end
      if (stall === 1'b1) begin
        stall_cnt++;
        if (cyc > 0) begin
          checks++;
          if (wb_valid !== 1'b0 || wb_regwrite !== 1'b0) begin
            errors++;
            $display("FAIL %s bubble wb_valid=%b wb_regwrite=%b want 0 0", tag, wb_valid, wb_regwrite);
          end
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s stall_bound stall still high after 64 cycles, want release", tag);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (stall_cnt != exp_stall) begin
      errors++; $display("FAIL %s stall_cycles got %0d want %0d", tag, stall_cnt, exp_stall);
    end
    checks++;
    if (saw_req !== acc) begin
      errors++; $display("FAIL %s request_issued got %b want %b", tag, saw_req, acc);
    end
    checks++;
    if (wb_valid !== v || wb_regwrite !== exp_rw) begin
      errors++;
      $display("FAIL %s wb_ctrl valid=%b regwrite=%b want %b %b", tag, wb_valid, wb_regwrite, v, exp_rw);
    end
    checks++;
    if (wb_rd !== rdi || wb_aluresult !== addr) begin
      errors++;
      $display("FAIL %s wb_payload rd=%0d alu=%h want %0d %h", tag, wb_rd, wb_aluresult, rdi, addr);
    end
    if (!memop || (acc && !store && !tmo)) begin
      checks++;
      if (wb_memdata !== exp_data) begin
        errors++; $display("FAIL %s wb_memdata got %h want %h", tag, wb_memdata, exp_data);
      end
    end
    if (acc && !store && !tmo) begin
      checks++;
      if (wb_memtoreg !== mtr) begin
        errors++; $display("FAIL %s wb_memtoreg got %b want %b", tag, wb_memtoreg, mtr);
      end
    end
    checks++;
    if (err !== exp_err || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s err_req err=%b req=%b want %b 0", tag, err, dmem_req, exp_err);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 ||
        dmem_wstrb !== 4'h0 || err !== 1'b0 || stall !== 1'b0 || pcsrc !== 1'b0) begin
      errors++;
      $display("FAIL reset dmem/err req=%b we=%b addr=%h wdata=%h wstrb=%b err=%b stall=%b want all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, err, stall);
    end
    checks++;
    if (wb_valid !== 1'b0 || wb_regwrite !== 1'b0 || wb_memtoreg !== 1'b0 || wb_rd !== 5'd0 ||
        wb_aluresult !== 32'h0 || wb_memdata !== 32'h0) begin
      errors++;
      $display("FAIL reset wb valid=%b rw=%b mtr=%b rd=%0d alu=%h md=%h want all 0",
               wb_valid, wb_regwrite, wb_memtoreg, wb_rd, wb_aluresult, wb_memdata);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_err = 1'b0;
  endtask

  task automatic test_alu();
    exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0, "alu");
    exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 5'd0, 0, "branch_taken");
    exec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0, 32'h0, 5'd9, 0, "invalid_load");
  endtask

  task automatic test_byte_load();
    exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd6, 3, "lb");
    exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd6, 3, "lbu");
    exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 5'd7, 0, "lw");
  endtask

  task automatic test_store();
    exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'hAABB_CCDD, 32'h0, 5'd0, 1, "sb");
    exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h1234_5678, 32'h0, 5'd0, 2, "sw");
    exec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0304, 32'h5555_AAAA, 32'hFFFF_FFFF, 5'd3, 0, "rd_and_wr");
  endtask

  task automatic test_misaligned();
    exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 5'd8, 0, "lw_misaligned");
  endtask

  task automatic test_timeout();
    exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'h1111_2222, 5'd10, 100, "lw_timeout");
    exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0777, 32'h0, 32'h0, 5'd11, 0, "add_after_timeout");
    exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0404, 32'h0, 32'h3333_4444, 5'd12, TO - 1, "ready_at_last_cycle");
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    clear_inputs();
    in_valid = 1'b1; memread = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; rd = 5'd7;
    aluresult = 32'h0000_0040;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid access_started req=%b want 1", dmem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || err !== 1'b0 || wb_valid !== 1'b0 || wb_regwrite !== 1'b0 ||
        wb_memtoreg !== 1'b0 || wb_rd !== 5'd0 || wb_aluresult !== 32'h0 || wb_memdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid cleared req=%b err=%b valid=%b rw=%b rd=%0d alu=%h want all 0",
               dmem_req, err, wb_valid, wb_regwrite, wb_rd, wb_aluresult);
    end
    exp_err = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_regwrite !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid after_release valid=%b rw=%b req=%b stall=%b want 0 0 0 0",
               wb_valid, wb_regwrite, dmem_req, stall);
    end
  endtask

  task automatic test_random();
    logic        v, mr, mw, mtr, rw, bt, us;
    logic [31:0] addr;
    int          kind;
    for (int n = 0; n < 150; n++) begin
      v    = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 5);
      addr = $urandom;
      mr = (kind == 1 || kind == 2 || kind == 5);
      mw = (kind == 3 || kind == 4 || kind == 5);
      bt = (kind == 2 || kind == 4) ? 1'b1 : ((kind == 5) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (!bt && $urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
      rw  = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind == 3 || kind == 4) ? 1'b0 : 1'b1;
      mtr = mr & !mw;
      if (kind == 5) mtr = 1'b1;
      us  = 1'($urandom_range(0, 1));
      exec(v, mr, mw, mtr, rw, bt, us, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           addr, $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 5), "random");
    end
  endtask

  task automatic test_back_to_back();
    exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0501, 32'h0000_00EE, 32'h0, 5'd0, 0, "b2b_sb");
    exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0501, 32'h0, 32'h0000_EE00, 5'd4, 0, "b2b_lb");
    exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0504, 32'h0, 32'h89AB_CDEF, 5'd2, 0, "b2b_lw");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_byte_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. It sits directly downstream of the EX/MEM pipeline register and upstream of writeback.
- Consumes the registered EX results: ALU result, store data, control bits, and the byte-type/unsigned flags.
- Performs lw/sw/lb/lbu/sb through a ready/valid data-memory port and stalls the pipeline while an access is outstanding.
- Resolves branch-taken and registers the MEM/WB payload.

Parameters:
- TIMEOUT, 255: maximum ACCESS cycles before an access is aborted (1..255).
- XLEN, 32: datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a live instruction
- aluresult  in  32  address or ALU result
- writedata  in  32  store data (rs2 after forwarding)
- memread  in  1  load
- memwrite  in  1  store
- memtoreg  in  1  writeback selects memory data
- regwrite  in  1  instruction writes rd
- bitype  in  1  byte access
- unsign  in  1  zero-extend byte load
- branch  in  1  branch instruction
- zero  in  1  branch condition true
- rd  in  5  destination register
- dmem_req  out  1  memory request valid
- dmem_we  out  1  write request
- dmem_addr  out  32  word-aligned address ({aluresult[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_ready  in  1  request accepted / read data valid this cycle
- dmem_rdata  in  32  read word
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- pcsrc  out  1  branch taken
- err  out  1  sticky fault (misaligned word or timeout)
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each  MEM/WB control
- wb_rd  out  5  MEM/WB destination
- wb_aluresult  out  32  MEM/WB ALU result
- wb_memdata  out  32  MEM/WB formatted load data

Behaviour:
- Reset (async on rst_n low): state=IDLE; timeout counter=0; err=0; all wb_* = 0.
  - The registered outputs dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb clear to 0 immediately.
  - A reset mid-ACCESS abandons the request; no MEM/WB update occurs.
- memop = in_valid & (memread | memwrite). If both memread and memwrite are set, memwrite wins and the op is treated as a store with no register write.
- Misaligned word access (bitype=0 with aluresult[1:0]!=0):
  - no request is issued; err sets;
  - the instruction passes to MEM/WB with wb_regwrite=0 in 1 cycle;
  - stall stays low.
- State IDLE:
  - Non-memory or invalid instruction: MEM/WB loads next edge (1-cycle latency); wb_valid=in_valid; wb_regwrite=regwrite&in_valid; wb_memdata=0.
  - Valid aligned memop: stall=1 combinationally this cycle; dmem_* are registered at the edge; go to ACCESS; counter=0.
- State ACCESS:
  - dmem_req=1, with dmem_addr, dmem_we, dmem_wdata, dmem_wstrb stable until dmem_ready.
  - stall=1 while dmem_ready=0.
  - On dmem_ready=1: stall=0 combinationally in the same cycle, so upstream advances on that edge. On that edge: MEM/WB loads, dmem_req drops, state returns to IDLE.
  - Back-to-back memops therefore cost 2 cycles minimum each; dmem_req is low for 1 cycle between them.
- Timeout: counter increments each ACCESS cycle without ready. When it reaches TIMEOUT-1 with no ready:
  - the access aborts and err sets;
  - MEM/WB loads with wb_regwrite=0 and wb_valid=1;
  - state returns to IDLE;
  - a dmem_ready arriving in that same cycle takes priority over the timeout.
- While stall=1: wb_valid=0 and wb_regwrite=0 each stalled cycle (bubble into WB). Inputs are held stable upstream.
- Store formatting:
  - word: wdata=writedata, wstrb=4'b1111.
  - byte: wdata={4{writedata[7:0]}}, wstrb=4'b0001<<aluresult[1:0].
- Load formatting:
  - word: memdata=dmem_rdata.
  - byte: b=dmem_rdata[8*aluresult[1:0] +: 8]; memdata = unsign ? {24'b0,b} : {{24{b[7]}},b}.
- pcsrc = in_valid & branch & zero, combinational and independent of state.
- err is sticky until reset.

Test Plan:
- Reset pulse during ACCESS (dmem_ready low) -> dmem_req=0 immediately, all wb_*=0, err=0; no MEM/WB update after release.
- ALU op: regwrite=1, rd=5, aluresult=0x1234 -> next edge wb_valid=1, wb_rd=5, wb_aluresult=0x1234, stall never asserted.
- lb, addr=0x103, rdata=0x80FF_0000, dmem_ready after 3 wait cycles:
  - expect stall high for 4 cycles;
  - wb_memdata=0xFFFFFF80;
  - the lbu variant gives 0x00000080.
- sb, addr=0x102, writedata=0xAABBCCDD -> dmem_we=1, dmem_addr=0x100, dmem_wdata=0xDDDDDDDD, dmem_wstrb=4'b0100, wb_regwrite=0.
- lw at addr=0x102 -> no dmem_req, err=1, wb_regwrite=0, stall=0.
- lw with dmem_ready held low, TIMEOUT=4:
  - abort after 4 ACCESS cycles; err=1; wb_regwrite=0; state IDLE;
  - a following add completes in 1 cycle.
